// File: rtl/pushbutton_debouncer.sv
// Purpose : synchronise, debounce and edge-detect N active-low pushbuttons.
// Latency : clean pin edge to PB_STATE/PB_PRESS/PB_RELEASE is DEBOUNCE_CYCLES + 2 CLK cycles.
// Backpr. : none; pure input conditioning, outputs are levels and one-cycle pulses.
//
// Optional feature macro: LONG_PRESS_EN
//   defined   -> per-button hold counter, PB_LONG pulses once per press after
//                LONG_PRESS_CYCLES cycles of PB_STATE held high.
//   undefined -> no hold counters, PB_LONG tied low (port kept for a stable interface).
//
// Ports
//   CLK         in   1          system clock, all state on rising edge
//   RST_n       in   1          asynchronous active-low reset
//   PB_n        in   N_BUTTONS  raw pushbutton pins, active low, asynchronous to CLK
//   PB_STATE    out  N_BUTTONS  debounced level, 1 = pressed
//   PB_PRESS    out  N_BUTTONS  one-cycle pulse on accepted press
//   PB_RELEASE  out  N_BUTTONS  one-cycle pulse on accepted release
//   PB_LONG     out  N_BUTTONS  one-cycle pulse at the long-press threshold

module pushbutton_debouncer #(
   parameter int N_BUTTONS         = 2,
   parameter int DEBOUNCE_CYCLES   = 500000,
   parameter int LONG_PRESS_CYCLES = 50000000
) (
   input  logic                 CLK,
   input  logic                 RST_n,
   input  logic [N_BUTTONS-1:0] PB_n,
   output logic [N_BUTTONS-1:0] PB_STATE,
   output logic [N_BUTTONS-1:0] PB_PRESS,
   output logic [N_BUTTONS-1:0] PB_RELEASE,
   output logic [N_BUTTONS-1:0] PB_LONG
);

   // Stability counter only ever holds 0 .. DEBOUNCE_CYCLES-1; keep at least one bit
   // so DEBOUNCE_CYCLES=1 still elaborates.
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Illegal configurations stop elaboration rather than silently misbehaving.
   if (N_BUTTONS < 1 || DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1) begin : g_bad_params
      $error("pushbutton_debouncer: N_BUTTONS, DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must be >= 1");
   end

   // Per-button debounce state: IDLE when the synchronised sample agrees with the
   // accepted level, COUNT while it disagrees and the stability window is running.
   typedef enum logic {
      DB_IDLE  = 1'b0,
      DB_COUNT = 1'b1
   } db_state_e;

   // ------------------------------------------------------------------
   // Two-flop synchroniser. Resets to 1 (pin released) so the debouncer
   // starts in agreement with an idle button. No logic between the flops.
   // ------------------------------------------------------------------
   logic [N_BUTTONS-1:0] sync1_q;
   logic [N_BUTTONS-1:0] sync2_q;
   logic [N_BUTTONS-1:0] sample;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= PB_n;
         sync2_q <= sync1_q;
      end
   end

   // Convert to active-high "pressed" sense.
   assign sample = ~sync2_q;

   // ------------------------------------------------------------------
   // Independent debounce slice per button.
   // ------------------------------------------------------------------
   for (genvar b = 0; b < N_BUTTONS; b++) begin : g_btn

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             level_q;
      logic             level_d;
      logic             press_q;
      logic             press_d;
      logic             release_q;
      logic             release_d;
      db_state_e        db_st;

      always_comb begin
         cnt_d     = '0;
         level_d   = level_q;
         press_d   = 1'b0;
         release_d = 1'b0;
         db_st     = (sample[b] == level_q) ? DB_IDLE : DB_COUNT;

         case (db_st)
            DB_IDLE: begin
               // Agreement (including a bounce back) restarts the window.
               cnt_d = '0;
            end
            DB_COUNT: begin
               if (cnt_q == CNT_LAST) begin
                  // Sample has disagreed for DEBOUNCE_CYCLES consecutive cycles:
                  // accept it. Counter returns to 0, so it never wraps.
                  level_d   = sample[b];
                  press_d   = sample[b];
                  release_d = ~sample[b];
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               cnt_d = '0;
            end
         endcase
      end

      always_ff @(posedge CLK or negedge RST_n) begin
         if (!RST_n) begin
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
         end
      end

      assign PB_STATE[b]   = level_q;
      assign PB_PRESS[b]   = press_q;
      assign PB_RELEASE[b] = release_q;

`ifdef LONG_PRESS_EN
      // Hold counter: counts cycles with the accepted level high, saturates at
      // LONG_PRESS_CYCLES so only one PB_LONG fires per press, clears on release.
      localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
      localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

      logic [HOLD_W-1:0] hold_q;
      logic [HOLD_W-1:0] hold_d;
      logic              long_q;
      logic              long_d;

      always_comb begin
         hold_d = hold_q;
         long_d = 1'b0;
         if (!level_q) begin
            hold_d = '0;
         end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
            // Pulse registers on the same edge the counter reaches the threshold.
            long_d = (hold_q == (HOLD_MAX - 1'b1));
         end
      end

      always_ff @(posedge CLK or negedge RST_n) begin
         if (!RST_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
         end else begin
            hold_q <= hold_d;
            long_q <= long_d;
         end
      end

      assign PB_LONG[b] = long_q;
`else
      assign PB_LONG[b] = 1'b0;
`endif

   end

endmodule

// File: tb/tb_pushbutton_debouncer.sv
// Directed bench for pushbutton_debouncer with N_BUTTONS=2, DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=10. Expected vectors are hand-derived: a pin change driven just
// after edge 0 is accepted on edge 6; a long press fires 10 edges after the press edge.

module tb_pushbutton_debouncer;

   logic       CLK = 1'b0;
   logic       RST_n = 1'b1;
   logic [1:0] PB_n = 2'b11;
   logic [1:0] PB_STATE;
   logic [1:0] PB_PRESS;
   logic [1:0] PB_RELEASE;
   logic [1:0] PB_LONG;

   int total = 0;
   int bad   = 0;

`ifdef LONG_PRESS_EN
   localparam bit LP_EN = 1'b1;
`else
   localparam bit LP_EN = 1'b0;
`endif

   always #5 CLK = ~CLK;

   pushbutton_debouncer #(
      .N_BUTTONS        (2),
      .DEBOUNCE_CYCLES  (4),
      .LONG_PRESS_CYCLES(10)
   ) dut (
      .CLK       (CLK),
      .RST_n     (RST_n),
      .PB_n      (PB_n),
      .PB_STATE  (PB_STATE),
      .PB_PRESS  (PB_PRESS),
      .PB_RELEASE(PB_RELEASE),
      .PB_LONG   (PB_LONG)
   );

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   function automatic logic [7:0] ev(input logic [1:0] st, input logic [1:0] pr,
                                     input logic [1:0] rl, input logic [1:0] lg);
      return {st, pr, rl, lg};
   endfunction

   task automatic chk(input string tag, input logic [7:0] exp);
      logic [7:0] obs;
      obs = {PB_STATE, PB_PRESS, PB_RELEASE, PB_LONG};
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed{st,pr,rl,lg}=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   initial begin
      logic [1:0] st_e;
      logic [1:0] pr_e;
      logic [1:0] rl_e;
      logic [1:0] lg_e;

      // 1. Reset with random pins, then idle after release.
      #1 RST_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         PB_n = 2'($urandom);
         tick(1);
         chk("reset_hold", ev(2'b00, 2'b00, 2'b00, 2'b00));
      end
      PB_n  = 2'b11;
      RST_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk("idle_after_reset", ev(2'b00, 2'b00, 2'b00, 2'b00));
      end

      // 2. Clean press on bit 0: accepted on edge 6.
      PB_n = 2'b10;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         st_e = (k >= 6) ? 2'b01 : 2'b00;
         pr_e = (k == 6) ? 2'b01 : 2'b00;
         chk("press0", ev(st_e, pr_e, 2'b00, 2'b00));
      end

      // Clean release on bit 0.
      PB_n = 2'b11;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         st_e = (k >= 6) ? 2'b00 : 2'b01;
         rl_e = (k == 6) ? 2'b01 : 2'b00;
         chk("release0", ev(st_e, 2'b00, rl_e, 2'b00));
      end

      // 3. Three-cycle glitch then 2-cycle bouncing: never 4 stable cycles.
      for (int i = 0; i < 3; i++) begin
         PB_n = 2'b10;
         tick(1);
         chk("glitch", ev(2'b00, 2'b00, 2'b00, 2'b00));
      end
      for (int i = 0; i < 30; i++) begin
         PB_n = (((i / 2) % 2) == 0) ? 2'b11 : 2'b10;
         tick(1);
         chk("bounce", ev(2'b00, 2'b00, 2'b00, 2'b00));
      end
      PB_n = 2'b11;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("bounce_tail", ev(2'b00, 2'b00, 2'b00, 2'b00));
      end

      // 4. Both buttons pressed together, then released together.
      PB_n = 2'b00;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         st_e = (k >= 6) ? 2'b11 : 2'b00;
         pr_e = (k == 6) ? 2'b11 : 2'b00;
         chk("press_both", ev(st_e, pr_e, 2'b00, 2'b00));
      end
      PB_n = 2'b11;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         st_e = (k >= 6) ? 2'b00 : 2'b11;
         rl_e = (k == 6) ? 2'b11 : 2'b00;
         chk("release_both", ev(st_e, 2'b00, rl_e, 2'b00));
      end

      // 5. Long hold on bit 1: press on edge 6, PB_LONG on edge 16 when enabled.
      PB_n = 2'b01;
      for (int k = 1; k <= 30; k++) begin
         tick(1);
         st_e = (k >= 6) ? 2'b10 : 2'b00;
         pr_e = (k == 6) ? 2'b10 : 2'b00;
         lg_e = (LP_EN && k == 16) ? 2'b10 : 2'b00;
         chk("long_hold", ev(st_e, pr_e, 2'b00, lg_e));
      end
      PB_n = 2'b11;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         st_e = (k >= 6) ? 2'b00 : 2'b10;
         rl_e = (k == 6) ? 2'b10 : 2'b00;
         chk("long_release", ev(st_e, 2'b00, rl_e, 2'b00));
      end
      PB_n = 2'b01;
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         st_e = (k >= 6) ? 2'b10 : 2'b00;
         pr_e = (k == 6) ? 2'b10 : 2'b00;
         lg_e = (LP_EN && k == 16) ? 2'b10 : 2'b00;
         chk("long_rearm", ev(st_e, pr_e, 2'b00, lg_e));
      end

      // 6. Bit 1 still held and pressed; press bit 0, reset at count 2.
      PB_n = 2'b00;
      tick(4);
      chk("pre_reset_count", ev(2'b10, 2'b00, 2'b00, 2'b00));
      RST_n = 1'b0;
      #1;
      chk("async_reset", ev(2'b00, 2'b00, 2'b00, 2'b00));
      tick(2);
      chk("reset_held", ev(2'b00, 2'b00, 2'b00, 2'b00));
      RST_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         st_e = (k >= 6) ? 2'b11 : 2'b00;
         pr_e = (k == 6) ? 2'b11 : 2'b00;
         chk("press_after_reset", ev(st_e, pr_e, 2'b00, 2'b00));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
